array_bus_arbiter: RTL and testbench
====================================

Name: array_bus_arbiter

Overview:
- Merges the two lanes of an array-style bus (in_data[0:1] / in_valid[0:1]) onto one shared output channel with valid/ready flow control.
- Sits downstream of the array-bus register stage and lets two producers share a single consumer.
- Each lane has a 2-entry FIFO. A round-robin arbiter with a configurable burst limit selects the next beat. A registered output stage holds it, and per-lane delivered-beat counters record traffic.

Parameters:
- DATA_W, 8, width of every data word.
- BURST, 1, maximum consecutive grants to one lane while the other lane has data pending (legal range 1..15).
- CNT_W, 16, width of each per-lane delivered-beat counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data[0:1]  input  DATA_W each  per-lane data.
- in_valid[0:1]  input  1 each  per-lane beat valid.
- in_ready[0:1]  output  1 each  per-lane FIFO can accept.
- out_data  output  DATA_W  granted beat data.
- out_valid  output  1  output register holds a beat.
- out_lane  output  1  source lane of the current output beat.
- out_ready  input  1  consumer accepts the beat.
- cnt_clr  input  1  synchronous clear of both beat counters.
- beat_cnt[0:1]  output  CNT_W each  delivered beats per lane, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFOs emptied; out_valid=0, out_data=0, out_lane=0.
  - Round-robin pointer = lane 0; burst counter = 0; beat_cnt[0:1] = 0.
  - in_valid is ignored while rst_n is low.
  - Reset mid-transfer discards all buffered beats; nothing is replayed.
- Lane FIFO:
  - 2 entries per lane; in_ready[i] = (count_i < 2), combinational from FIFO occupancy only.
  - Push when in_valid[i] && in_ready[i]; order is preserved within a lane.
  - Push and pop on the same cycle are allowed: count is unchanged and data order is preserved.
  - Pushing while full is impossible by construction because in_ready is low.
- Output stage:
  - load = !out_valid || out_ready.
  - On load with at least one FIFO non-empty: pop the granted FIFO head into out_data, set out_lane, set out_valid=1.
  - On load with both FIFOs empty: out_valid=0 and out_data holds its last value.
  - While out_valid && !out_ready: out_data and out_lane are held stable and no FIFO is popped.
  - Throughput is 1 beat/cycle when out_ready is held high.
  - Latency: a beat accepted on cycle t appears with out_valid on cycle t+2 (no bypass).
- Arbitration (evaluated only on load):
  - Only one lane non-empty: grant that lane.
  - Both lanes non-empty: grant the pointer lane unless the burst counter equals BURST; in that case grant the other lane.
  - Burst counter after a grant:
    - increments if the same lane as the previous grant was granted while the other lane was pending;
    - set to 1 on a lane change;
    - set to 1 when the other lane was empty.
  - Pointer after each grant is set to the granted lane when the burst counter < BURST, otherwise to the other lane.
  - With BURST=1 the arbiter is strict alternation under contention.
  - No starvation: a pending lane is granted within BURST+1 loads.
- Counters:
  - beat_cnt[out_lane] increments on out_valid && out_ready and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle: the result is 0.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_data=0, out_lane=0, in_ready=2'b11, beat_cnt=0,0.
- Lane 0 only: 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first accept, out_lane=0, beat_cnt[0]=3.
- Contention, BURST=1: lane 0 streams 0xA0.., lane 1 streams 0xB0.. continuously -> output alternates A0,B0,A1,B1,...; with BURST=3 the output is A0,A1,A2,B0,B1,B2,....
- Backpressure: out_ready=0 for 6 cycles under both lanes streaming -> out_data/out_lane stable, in_ready[0:1] fall to 0 once each FIFO holds 2. On release, all beats are delivered in per-lane order with none lost or duplicated.
- rst_n pulsed low for 1 cycle with both FIFOs full and out_valid=1 -> outputs are 0 immediately (asynchronously). After release, no stale beat is emitted; new traffic resumes with lane 0 priority.
- Counter edges: CNT_W=4, deliver 20 lane-1 beats -> beat_cnt[1]=15. cnt_clr asserted on the same cycle as a delivery -> beat_cnt[1]=0.

Source files
------------

// File: rtl/array_bus_arbiter_if.sv
// Two-lane array-bus input side plus the merged valid/ready output channel.
interface array_bus_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [1:0][DATA_W-1:0] in_data;
    logic [1:0]             in_valid;
    logic [1:0]             in_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_lane;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_lane
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_lane
    );
endinterface

// File: rtl/array_bus_arbiter.sv
// Two-lane merge: per-lane 2-deep FIFO and beat counter, burst-limited
// round-robin grant, registered output stage.
module array_bus_arbiter_lane #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_valid,
    input  logic              pop,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    output logic              ready,
    output logic              nonempty,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  beat_cnt
);
    logic [1:0][DATA_W-1:0] mem;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;
    logic                   push;

    assign ready    = (count != 2'd2);
    assign nonempty = (count != 2'd0);
    assign head     = mem[rd_ptr];
    assign push     = push_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Clear wins over a same-cycle delivery; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         beat_cnt <= '0;
        else if (cnt_clr)                   beat_cnt <= '0;
        else if (cnt_inc && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
    end
endmodule

module array_bus_arbiter #(
    parameter int DATA_W = 8,
    parameter int BURST  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    array_bus_arbiter_if.slave    bus,
    input  logic                  cnt_clr,
    output logic [1:0][CNT_W-1:0] beat_cnt
);
    localparam logic [3:0] BURST_L = 4'(BURST);

    logic [1:0]             nonempty;
    logic [1:0]             ready;
    logic [1:0]             pop;
    logic [1:0]             cnt_inc;
    logic [1:0][DATA_W-1:0] head;
    logic                   load;
    logic                   any;
    logic                   grant;
    logic                   ptr;
    logic                   ptr_nxt;
    logic [3:0]             burst;
    logic [3:0]             burst_nxt;

    assign bus.in_ready = ready;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        assign pop[i]     = load && any && (grant == 1'(i));
        assign cnt_inc[i] = bus.out_valid && bus.out_ready && (bus.out_lane == 1'(i));

        array_bus_arbiter_lane #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .push_data  (bus.in_data[i]),
            .push_valid (bus.in_valid[i]),
            .pop        (pop[i]),
            .cnt_clr    (cnt_clr),
            .cnt_inc    (cnt_inc[i]),
            .ready      (ready[i]),
            .nonempty   (nonempty[i]),
            .head       (head[i]),
            .beat_cnt   (beat_cnt[i])
        );
    end

    // out_lane doubles as "previous grant" for the burst bookkeeping.
    always_comb begin
        load = !bus.out_valid || bus.out_ready;
        any  = |nonempty;
        if (&nonempty) grant = (burst == BURST_L) ? ~bus.out_lane : ptr;
        else           grant = nonempty[1];
        burst_nxt = (&nonempty && grant == bus.out_lane) ? burst + 4'd1 : 4'd1;
        ptr_nxt   = (burst_nxt < BURST_L) ? grant : ~grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_lane  <= 1'b0;
            ptr           <= 1'b0;
            burst         <= 4'd0;
        end else if (load) begin
            bus.out_valid <= any;
            if (any) begin
                bus.out_data <= head[grant];
                bus.out_lane <= grant;
                ptr          <= ptr_nxt;
                burst        <= burst_nxt;
            end
        end
    end
endmodule

// File: tb/tb_array_bus_arbiter.sv
// Drives a BURST=1/CNT_W=4 and a BURST=3/CNT_W=16 arbiter with the same
// stimulus and compares both against a queue-based reference each cycle.
module tb_array_bus_arbiter;
    localparam int DW = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic cnt_clr = 1'b0;
    logic [1:0][3:0]  bc0;
    logic [1:0][15:0] bc1;

    array_bus_arbiter_if #(.DATA_W(DW)) bus0 ();
    array_bus_arbiter_if #(.DATA_W(DW)) bus1 ();

    array_bus_arbiter #(.DATA_W(DW), .BURST(1), .CNT_W(4)) u_b1 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .cnt_clr(cnt_clr), .beat_cnt(bc0));
    array_bus_arbiter #(.DATA_W(DW), .BURST(3), .CNT_W(16)) u_b3 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .cnt_clr(cnt_clr), .beat_cnt(bc1));

    always #5 clk = ~clk;

    // stimulus state
    logic [1:0] vin;
    logic       rdy;
    logic       smode;
    logic [7:0] dd [2];
    int         seq [2][2];

    // reference state: lane queues, output register, contested streak, counters
    logic [7:0] mq [2][2][$];
    logic       mov [2];
    logic [7:0] mdat [2];
    logic       mol [2];
    int         mrun [2];
    int         mbc [2][2];
    logic [7:0] lg [2][$];

    int npass = 0;
    int ntot  = 0;
    int nfail = 0;

    function automatic int bur(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic logic [7:0] dval(int k, int l);
        if (smode) return ((l == 1) ? 8'hB0 : 8'hA0) + 8'(seq[k][l]);
        return dd[l];
    endfunction

    function automatic logic [31:0] dut(int k, int f);
        case (f)
            0: return (k == 0) ? 32'(bus0.out_valid) : 32'(bus1.out_valid);
            1: return (k == 0) ? 32'(bus0.out_data)  : 32'(bus1.out_data);
            2: return (k == 0) ? 32'(bus0.out_lane)  : 32'(bus1.out_lane);
            3: return (k == 0) ? 32'(bus0.in_ready)  : 32'(bus1.in_ready);
            4: return (k == 0) ? 32'(bc0[0]) : 32'(bc1[0]);
            default: return (k == 0) ? 32'(bc0[1]) : 32'(bc1[1]);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int l = 0; l < 2; l++) begin
            bus0.in_data[l] = dval(0, l);
            bus1.in_data[l] = dval(1, l);
        end
        bus0.in_valid  = vin;
        bus1.in_valid  = vin;
        bus0.out_ready = rdy;
        bus1.out_ready = rdy;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model(int k);
        logic [7:0] d0, d1;
        bit p0, p1, e0, e1, g;
        if (!rst_n) begin
            mq[k][0].delete(); mq[k][1].delete();
            mov[k] = 1'b0; mdat[k] = 8'h00; mol[k] = 1'b0; mrun[k] = 0;
            mbc[k][0] = 0; mbc[k][1] = 0;
            return;
        end
        d0 = dval(k, 0);
        d1 = dval(k, 1);
        p0 = vin[0] && (mq[k][0].size() < 2);
        p1 = vin[1] && (mq[k][1].size() < 2);
        if (cnt_clr) begin
            mbc[k][0] = 0; mbc[k][1] = 0;
        end else if (mov[k] && rdy && mbc[k][mol[k]] < cmax(k)) begin
            mbc[k][mol[k]]++;
        end
        if (!mov[k] || rdy) begin
            e0 = mq[k][0].size() > 0;
            e1 = mq[k][1].size() > 0;
            if (e0 || e1) begin
                if (e0 && e1) g = (mrun[k] == bur(k)) ? !mol[k] : mol[k];
                else          g = e1;
                mrun[k] = (e0 && e1 && g == mol[k]) ? mrun[k] + 1 : 1;
                mdat[k] = mq[k][g].pop_front();
                mol[k]  = g;
                mov[k]  = 1'b1;
            end else begin
                mov[k] = 1'b0;
            end
        end
        if (p0) begin mq[k][0].push_back(d0); seq[k][0]++; end
        if (p1) begin mq[k][1].push_back(d1); seq[k][1]++; end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d_out_valid", k), dut(k, 0), 32'(mov[k]));
            chk($sformatf("i%0d_out_data", k),  dut(k, 1), 32'(mdat[k]));
            chk($sformatf("i%0d_out_lane", k),  dut(k, 2), 32'(mol[k]));
            chk($sformatf("i%0d_in_ready", k),  dut(k, 3),
                {30'd0, mq[k][1].size() < 2, mq[k][0].size() < 2});
            chk($sformatf("i%0d_beat_cnt0", k), dut(k, 4), 32'(mbc[k][0]));
            chk($sformatf("i%0d_beat_cnt1", k), dut(k, 5), 32'(mbc[k][1]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply();
        #1;
        if (bus0.out_valid && rdy) lg[0].push_back(bus0.out_data);
        if (bus1.out_valid && rdy) lg[1].push_back(bus1.out_data);
        model(0);
        model(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk_seq(int k, string nm, int n, input logic [7:0] e [6]);
        for (int i = 0; i < n; i++)
            chk($sformatf("i%0d_%s_%0d", k, nm, i),
                (i < lg[k].size()) ? 32'(lg[k][i]) : 32'hDEAD, 32'(e[i]));
    endtask

    task automatic clear_seq();
        for (int k = 0; k < 2; k++) begin
            seq[k][0] = 0; seq[k][1] = 0;
            lg[k].delete();
        end
    endtask

    initial begin
        vin = 2'b00; rdy = 1'b1; smode = 1'b0; dd[0] = 8'h00; dd[1] = 8'h00;
        clear_seq();
        apply();
        model(0);
        model(1);

        // reset state with idle inputs
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_in_ready_b1", 32'(bus0.in_ready), 32'h3);
        chk("rst_in_ready_b3", 32'(bus1.in_ready), 32'h3);
        chk("rst_out_data_b1", 32'(bus0.out_data), 32'h0);
        rst_n = 1'b1;
        step();

        // lane 0 alone, out_ready high
        clear_seq();
        vin = 2'b01;
        dd[0] = 8'h11; step();
        dd[0] = 8'h22; step();
        dd[0] = 8'h33; step();
        vin = 2'b00;
        repeat (4) step();
        chk_seq(0, "lane0", 3, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00});
        chk_seq(1, "lane0", 3, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00});
        chk("lane0_cnt_b1", 32'(bc0[0]), 32'd3);
        chk("lane0_cnt_b3", 32'(bc1[0]), 32'd3);

        // backpressure with both lanes streaming, then drain
        clear_seq();
        smode = 1'b1; vin = 2'b11; rdy = 1'b0;
        repeat (6) step();
        chk("bp_in_ready_b1", 32'(bus0.in_ready), 32'h0);
        chk("bp_in_ready_b3", 32'(bus1.in_ready), 32'h0);
        chk("bp_out_valid_b1", 32'(bus0.out_valid), 32'h1);
        rdy = 1'b1; vin = 2'b00;
        repeat (8) step();

        // fill everything, then pulse reset asynchronously
        vin = 2'b11; rdy = 1'b0;
        repeat (4) step();
        chk("pre_rst_valid_b3", 32'(bus1.out_valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model(0);
        model(1);
        check_all();
        chk("async_rst_valid_b1", 32'(bus0.out_valid), 32'h0);
        chk("async_rst_data_b3", 32'(bus1.out_data), 32'h0);
        step();
        rst_n = 1'b1;
        vin = 2'b00; rdy = 1'b1;
        repeat (2) step();

        // contention from a fresh reset: BURST=1 alternates, BURST=3 runs of three
        clear_seq();
        vin = 2'b11;
        repeat (12) step();
        vin = 2'b00;
        repeat (6) step();
        chk_seq(0, "alt", 6, '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2});
        chk_seq(1, "burst3", 6, '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2});

        // counter saturation and clear-over-increment
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        vin = 2'b10;
        repeat (20) step();
        vin = 2'b00;
        repeat (4) step();
        chk("sat_cnt1_b1", 32'(bc0[1]), 32'd15);
        chk("sat_cnt1_b3", 32'(bc1[1]), 32'd20);
        vin = 2'b10; step();
        vin = 2'b00; step();
        chk("clr_pre_valid_b1", 32'(bus0.out_valid), 32'h1);
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        chk("clr_cnt1_b1", 32'(bc0[1]), 32'd0);
        chk("clr_cnt1_b3", 32'(bc1[1]), 32'd0);

        // randomized traffic, backpressure and occasional clears
        smode = 1'b0;
        repeat (400) begin
            vin     = 2'($urandom);
            rdy     = ($urandom_range(0, 3) != 0);
            dd[0]   = 8'($urandom);
            dd[1]   = 8'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
            step();
        end
        cnt_clr = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
